matrix_sm: RTL and testbench
============================

// Module: matrix_sm
// PURPOSE
// - HUB75 scan driver for a 64x64 RGB LED panel (1/32 scan, two half-panels on R1G1B1 / R2G2B2).
// - Shifts one row pair of solid colour (rgb1 upper half, rgb2 lower half) per scan, then blanks,
//   latches and advances the row address A..E.
// - Sits under matrixMain; its clock is the 25 MHz panel clock domain.
// PARAMETERS
// - COLS       64  columns shifted per row (serial CLK pulses per scan line)
// - ROW_PAIRS  32  row pairs addressed by {E,D,C,B,A}; must be a power of 2, at most 32
// - HOLD       0   extra cycles OE stays high after LAT, before shifting resumes (0..255)
// PORTS
// - clock  in   1  single clock; all logic on its rising edge
// - reset  in   1  synchronous, active-high
// - rgb1   in   3  upper-half colour {R,G,B}; sampled at the start of each column
// - rgb2   in   3  lower-half colour {R,G,B}; sampled at the start of each column
// - A,B,C,D,E  out  1 each  row address, {E,D,C,B,A} = row index, A is the LSB
// - R1,G1,B1   out  1 each  upper-half serial data
// - R2,G2,B2   out  1 each  lower-half serial data
// - CLK  out  1  panel shift clock
// - LAT  out  1  panel latch, active high
// - OE   out  1  panel output enable, active low (1 = blanked)
// BEHAVIOUR
// - All outputs are registered. During reset: state=SHIFT, col=0, phase=0, row=0, A..E=0, CLK=0,
//   LAT=0, OE=1, all data outputs 0. Reset asserted mid-scan aborts the scan on the next edge.
// - SHIFT: 2 cycles per column.
//   - phase 0: CLK=0; R1G1B1<=rgb1, R2G2B2<=rgb2 (R=bit2, G=bit1, B=bit0).
//   - phase 1: CLK=1; data held.
//   - OE=0 throughout, except the first SHIFT after reset, where OE=1 until the first LATCH.
//   - After phase 1 of column COLS-1, go to BLANK. A scan line is 2*COLS cycles (128 by default).
// - BLANK (1 cycle): CLK=0, OE=1, LAT=0.
// - LATCH (1 cycle): OE=1, LAT=1, {E,D,C,B,A}<=row. row<=row+1 mod ROW_PAIRS (31 wraps to 0).
// - UNBLANK (1+HOLD cycles): OE=1, LAT=0. Then SHIFT with col=0, phase=0, OE=0.
// - Period: 2*COLS+3+HOLD cycles per row pair (131 by default). Frame: 32 such periods.
// - Invariants: CLK and LAT are never high in the same cycle. LAT is high only while OE=1.
// - rgb inputs may change on any cycle. Only the phase-0 sample is shifted out.
// - Address {E,D,C,B,A} changes only in the LATCH cycle.
// STRUCTURE
// - Package matrix_pkg: typedef enum logic [1:0] {SHIFT,BLANK,LATCH,UNBLANK} state_t; constants
//   COLS_DEF=64 and ROW_PAIRS_DEF=32.
// - Sub-module counter #(n, k): clk, reset (sync, active high), count[n-1:0], rollover.
//   - count increments each cycle and wraps k-1 -> 0.
//   - rollover=1 only in the cycle count==k-1.
//   - Reset value: count=0, rollover=0.
//   - Instantiate as the column counter (n=$clog2(COLS)+1, k=2*COLS) during SHIFT.
//   - Also reused by the top level for clock-enable generation (k=4 gives 25 MHz, k=10^8 gives 1 s).
// - No other sub-modules. The FSM, row register and output registers are inline.
// TESTING
// - Reset held 3 cycles, then released -> during reset OE=1, LAT=0, CLK=0, addr=0, data=0;
//   first CLK rising output occurs 2 cycles after release.
// - rgb1=3'b111, rgb2=3'b000 constant -> exactly 64 CLK rising edges per line, R1=G1=B1=1 and
//   R2=G2=B2=0 at every CLK rise; LAT pulse is 1 cycle wide at cycle 129 of the line (0-based).
// - Run 32 lines -> {E,D,C,B,A} takes 0,1,...,31 at successive LAT pulses, then wraps to 0 on the
//   33rd LAT; period between LAT pulses is 131 cycles.
// - Change rgb1 from 3'b101 to 3'b010 at a phase-1 cycle -> the next column shifts R1=0,G1=1,B1=0;
//   the current column stays 1,0,1.
// - Assert reset for 1 cycle mid-line (column 20) -> next cycle all outputs are at reset values and
//   the following line starts at column 0, with the first LAT after it driving address 0.
// - counter n=3 k=4 standalone -> count 0,1,2,3,0,... and rollover high on every 4th cycle only;
//   reset mid-count returns count to 0.

Source files
------------

// File: rtl/matrix_pkg.sv
// matrix_pkg: shared types and default geometry for the HUB75 scan driver.
package matrix_pkg;

  typedef enum logic [1:0] {
    SHIFT   = 2'd0,
    BLANK   = 2'd1,
    LATCH   = 2'd2,
    UNBLANK = 2'd3
  } state_t;

  localparam int COLS_DEF      = 64;
  localparam int ROW_PAIRS_DEF = 32;

endpackage

// File: rtl/matrix_sm_counter.sv
// counter: free-running modulo-k up-counter with a registered terminal flag.
// rollover is high exactly in the cycle where count == k-1 (k >= 2).
module counter #(
  parameter int n = 3,
  parameter int k = 4
) (
  input  logic         clk,
  input  logic         reset,
  output logic [n-1:0] count,
  output logic         rollover
);

  localparam logic [n-1:0] LAST = n'(k - 1);
  localparam logic [n-1:0] PREV = n'(k - 2);

  // count wraps k-1 -> 0; rollover is registered alongside so both line up
  always_ff @(posedge clk) begin
    if (reset) begin
      count    <= '0;
      rollover <= 1'b0;
    end else if (count == LAST) begin
      count    <= '0;
      rollover <= 1'b0;
    end else begin
      count    <= count + n'(1);
      rollover <= (count == PREV);
    end
  end

endmodule

// File: rtl/matrix_sm.sv
// matrix_sm: HUB75 scan driver, one solid-colour row pair per scan line.
//
// state   | meaning
// SHIFT   | clock COLS columns out, 2 cycles each (phase 0 CLK low + data load, phase 1 CLK high)
// BLANK   | CLK low, panel blanked ahead of the latch
// LATCH   | LAT pulse, address takes the row pointer, row pointer advances
// UNBLANK | 1+HOLD blanked cycles before the next line starts shifting
module matrix_sm
  import matrix_pkg::*;
#(
  parameter int COLS      = COLS_DEF,
  parameter int ROW_PAIRS = ROW_PAIRS_DEF,
  parameter int HOLD      = 0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [2:0] rgb1,
  input  logic [2:0] rgb2,
  output logic       A,
  output logic       B,
  output logic       C,
  output logic       D,
  output logic       E,
  output logic       R1,
  output logic       G1,
  output logic       B1,
  output logic       R2,
  output logic       G2,
  output logic       B2,
  output logic       CLK,
  output logic       LAT,
  output logic       OE
);

  localparam int CW = $clog2(COLS) + 1;

  state_t        r_state, w_state_nx;
  logic [CW-1:0] w_count;
  logic          w_rollover, w_cnt_rst, w_phase, w_col_unused;
  logic [4:0]    r_row, r_addr;
  logic [7:0]    r_hold;
  logic          r_first;
  logic [2:0]    r_rgb1, r_rgb2;
  logic          r_clk, r_lat, r_oe;

  // The column/phase counter only runs while shifting; it sits at 0 otherwise
  // so every line starts at column 0, phase 0.
  assign w_cnt_rst = reset | (r_state != SHIFT);

  counter #(.n(CW), .k(2 * COLS)) u_col_cnt (
    .clk      (clock),
    .reset    (w_cnt_rst),
    .count    (w_count),
    .rollover (w_rollover)
  );

  assign w_phase      = w_count[0];
  assign w_col_unused = ^w_count[CW-1:1];

  // state register
  always_ff @(posedge clock) begin
    if (reset) r_state <= SHIFT;
    else       r_state <= w_state_nx;
  end

  // next-state decode
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      SHIFT:   if (w_rollover) w_state_nx = BLANK;
      BLANK:   w_state_nx = LATCH;
      LATCH:   w_state_nx = UNBLANK;
      UNBLANK: if (r_hold == 8'd0) w_state_nx = SHIFT;
      default: w_state_nx = SHIFT;
    endcase
  end

  // registered panel outputs, row pointer and hold down-counter
  always_ff @(posedge clock) begin
    if (reset) begin
      r_row   <= 5'd0;
      r_addr  <= 5'd0;
      r_hold  <= 8'd0;
      r_first <= 1'b1;
      r_rgb1  <= 3'd0;
      r_rgb2  <= 3'd0;
      r_clk   <= 1'b0;
      r_lat   <= 1'b0;
      r_oe    <= 1'b1;
    end else begin
      case (r_state)
        SHIFT: begin
          r_lat <= 1'b0;
          // stays blanked until the first line after reset has been latched
          r_oe  <= r_first;
          r_clk <= w_phase;
          if (!w_phase) begin
            r_rgb1 <= rgb1;
            r_rgb2 <= rgb2;
          end
        end
        BLANK: begin
          r_clk <= 1'b0;
          r_lat <= 1'b0;
          r_oe  <= 1'b1;
        end
        LATCH: begin
          r_lat   <= 1'b1;
          r_oe    <= 1'b1;
          r_addr  <= r_row;
          r_row   <= (r_row == 5'(ROW_PAIRS - 1)) ? 5'd0 : r_row + 5'd1;
          r_hold  <= 8'(HOLD);
          r_first <= 1'b0;
        end
        UNBLANK: begin
          r_lat <= 1'b0;
          r_oe  <= 1'b1;
          if (r_hold != 8'd0) r_hold <= r_hold - 8'd1;
        end
        default: begin
          r_lat <= 1'b0;
          r_oe  <= 1'b1;
        end
      endcase
    end
  end

  assign {E, D, C, B, A} = r_addr;
  assign {R1, G1, B1}    = r_rgb1;
  assign {R2, G2, B2}    = r_rgb2;
  assign CLK             = r_clk;
  assign LAT             = r_lat;
  assign OE              = r_oe;

endmodule

// File: tb/tb_matrix_sm.sv
// tb_matrix_sm: default panel driver plus a small 4-column/4-row/HOLD=3 instance,
// and a standalone counter, all checked against a cycle-position model.
module tb_matrix_sm;

  localparam int C0 = 64, RP0 = 32, H0 = 0;
  localparam int C1 = 4,  RP1 = 4,  H1 = 3;
  localparam int PER0 = 2 * C0 + 3 + H0;

  logic       clock = 1'b0;
  logic       reset;
  logic [2:0] rgb1, rgb2;
  logic       c_reset;
  wire  [2:0] c_count;
  wire        c_roll;

  wire [1:0] A, B, C, D, E, R1, G1, B1, R2, G2, B2, CLK, LAT, OE;

  always #5 clock = ~clock;

  matrix_sm u_dut0 (
    .clock(clock), .reset(reset), .rgb1(rgb1), .rgb2(rgb2),
    .A(A[0]), .B(B[0]), .C(C[0]), .D(D[0]), .E(E[0]),
    .R1(R1[0]), .G1(G1[0]), .B1(B1[0]), .R2(R2[0]), .G2(G2[0]), .B2(B2[0]),
    .CLK(CLK[0]), .LAT(LAT[0]), .OE(OE[0])
  );

  matrix_sm #(.COLS(C1), .ROW_PAIRS(RP1), .HOLD(H1)) u_dut1 (
    .clock(clock), .reset(reset), .rgb1(rgb1), .rgb2(rgb2),
    .A(A[1]), .B(B[1]), .C(C[1]), .D(D[1]), .E(E[1]),
    .R1(R1[1]), .G1(G1[1]), .B1(B1[1]), .R2(R2[1]), .G2(G2[1]), .B2(B2[1]),
    .CLK(CLK[1]), .LAT(LAT[1]), .OE(OE[1])
  );

  counter #(.n(3), .k(4)) u_cnt (
    .clk(clock), .reset(c_reset), .count(c_count), .rollover(c_roll)
  );

  int         n_checks = 0;
  int         n_err    = 0;
  int         cyc      = 0;
  int         m_t[2];
  logic [2:0] m_d1[2], m_d2[2];
  int         m_c;
  int         rises, last_lat;
  logic       prev_clk0;
  logic [4:0] lat_q[$];

  function automatic int p_cols(input int k);  return (k == 0) ? C0 : C1;   endfunction
  function automatic int p_rows(input int k);  return (k == 0) ? RP0 : RP1; endfunction
  function automatic int p_hold(input int k);  return (k == 0) ? H0 : H1;   endfunction

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s dut%0d cycle %0d: observed %0h expected %0h", tag, k, cyc, obs, exp);
    end
  endtask

  // One clock: apply inputs, step the models, compare every output.
  task automatic tick(input logic rst, input logic [2:0] v1, input logic [2:0] v2, input logic crst);
    reset = rst; rgb1 = v1; rgb2 = v2; c_reset = crst;
    @(posedge clock);
    #1;
    cyc++;
    for (int k = 0; k < 2; k++) begin
      int c, per, w, l;
      logic e_clk, e_lat, e_oe;
      logic [4:0] e_addr;
      c   = p_cols(k);
      per = 2 * c + 3 + p_hold(k);
      if (rst) begin
        m_t[k] = -1; m_d1[k] = 3'd0; m_d2[k] = 3'd0;
        e_clk = 1'b0; e_lat = 1'b0; e_oe = 1'b1; e_addr = 5'd0;
      end else begin
        m_t[k]++;
        w = m_t[k] % per;
        l = m_t[k] / per;
        if (w < 2 * c && w % 2 == 0) begin
          m_d1[k] = v1; m_d2[k] = v2;
        end
        e_clk = (w < 2 * c) && (w % 2 == 1);
        e_lat = (w == 2 * c + 1);
        e_oe  = !((w < 2 * c) && (l >= 1));
        if (w >= 2 * c + 1) e_addr = 5'(l % p_rows(k));
        else if (l == 0)    e_addr = 5'd0;
        else                e_addr = 5'((l - 1) % p_rows(k));
      end
      chk("clk",  k, 32'(CLK[k]), 32'(e_clk));
      chk("lat",  k, 32'(LAT[k]), 32'(e_lat));
      chk("oe",   k, 32'(OE[k]),  32'(e_oe));
      chk("addr", k, 32'({E[k], D[k], C[k], B[k], A[k]}), 32'(e_addr));
      chk("rgb1_out", k, 32'({R1[k], G1[k], B1[k]}), 32'(m_d1[k]));
      chk("rgb2_out", k, 32'({R2[k], G2[k], B2[k]}), 32'(m_d2[k]));
      chk("clk_and_lat", k, 32'(CLK[k] & LAT[k]), 32'd0);
      chk("lat_while_oe_low", k, 32'(LAT[k] & ~OE[k]), 32'd0);
    end

    if (crst) m_c = 0;
    else      m_c = (m_c + 1) % 4;
    chk("cnt_count", 2, 32'(c_count), 32'(m_c));
    chk("cnt_rollover", 2, 32'(c_roll), 32'((!crst) && (m_c == 3)));

    if (rst) begin
      rises = 0; last_lat = -1;
    end else begin
      if (CLK[0] === 1'b1 && prev_clk0 === 1'b0) rises++;
      if (LAT[0] === 1'b1) begin
        chk("clk_rises_per_line", 0, 32'(rises), 32'(C0));
        rises = 0;
        if (last_lat >= 0) chk("lat_period", 0, 32'(cyc - last_lat), 32'(PER0));
        last_lat = cyc;
        lat_q.push_back({E[0], D[0], C[0], B[0], A[0]});
      end
    end
    prev_clk0 = CLK[0];
  endtask

  initial begin
    reset = 1'b1; rgb1 = 3'd0; rgb2 = 3'd0; c_reset = 1'b1;
    m_c = 0; rises = 0; last_lat = -1; prev_clk0 = 1'b0;
    m_t[0] = -1; m_t[1] = -1;
    m_d1[0] = 3'd0; m_d1[1] = 3'd0; m_d2[0] = 3'd0; m_d2[1] = 3'd0;

    // reset held 3 cycles
    repeat (3) tick(1'b1, 3'd0, 3'd0, 1'b1);
    chk("reset_oe", 0, 32'(OE[0]), 32'd1);

    // release: CLK low on the first cycle, high on the second
    lat_q.delete();
    tick(1'b0, 3'b111, 3'b000, 1'b0);
    chk("first_clk_low", 0, 32'(CLK[0]), 32'd0);
    tick(1'b0, 3'b111, 3'b000, 1'b0);
    chk("first_clk_rise", 0, 32'(CLK[0]), 32'd1);

    // solid colour for a full frame plus one wrap of the address
    for (int i = 0; i < 40 * PER0 && lat_q.size() < 33; i++)
      tick(1'b0, 3'b111, 3'b000, 1'b0);
    chk("lat_count_frame", 0, 32'(lat_q.size()), 32'd33);
    for (int i = 0; i < lat_q.size(); i++)
      chk("lat_addr_seq", 0, 32'(lat_q[i]), 32'(i % 32));

    // random colours, with a mid-count reset of the standalone counter
    for (int i = 0; i < 400; i++)
      tick(1'b0, 3'($urandom), 3'($urandom), (i == 150) || (i == 153));

    // colour change on a phase-1 cycle
    tick(1'b0, 3'b101, 3'($urandom), 1'b0);
    tick(1'b0, 3'b101, 3'($urandom), 1'b0);
    for (int i = 0; i < 300 && !((((m_t[0] + 1) % PER0) % 2 == 1) && (((m_t[0] + 1) % PER0) < 2 * C0 - 1)); i++)
      tick(1'b0, 3'b101, 3'($urandom), 1'b0);
    tick(1'b0, 3'b010, 3'($urandom), 1'b0);
    chk("cur_col_holds", 0, 32'({R1[0], G1[0], B1[0]}), 32'(3'b101));
    tick(1'b0, 3'b010, 3'($urandom), 1'b0);
    chk("next_col_new", 0, 32'({R1[0], G1[0], B1[0]}), 32'(3'b010));
    tick(1'b0, 3'b010, 3'($urandom), 1'b0);

    // one-cycle reset at column 20 of a line with the panel enabled
    for (int i = 0; i < 3 * PER0 && !(m_t[0] >= PER0 && (m_t[0] % PER0) == 40); i++)
      tick(1'b0, 3'($urandom), 3'($urandom), 1'b0);
    chk("pre_reset_oe_low", 0, 32'(OE[0]), 32'd0);
    tick(1'b1, 3'($urandom), 3'($urandom), 1'b0);
    chk("midline_reset_oe", 0, 32'(OE[0]), 32'd1);
    chk("midline_reset_data", 0, 32'({R1[0], G1[0], B1[0], R2[0], G2[0], B2[0]}), 32'd0);
    lat_q.delete();
    for (int i = 0; i < 2 * PER0 && lat_q.size() < 1; i++)
      tick(1'b0, 3'($urandom), 3'($urandom), 1'b0);
    chk("lat_after_reset_seen", 0, 32'(lat_q.size()), 32'd1);
    chk("lat_after_reset_addr", 0, 32'((lat_q.size() > 0) ? lat_q[0] : 5'h1f), 32'd0);

    for (int i = 0; i < 200; i++)
      tick(1'b0, 3'($urandom), 3'($urandom), 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
